// File: rtl/vga_layer_mixer.sv
// VGA 640x480@60 raster generator and fixed-priority layer compositor.
// Runs off the 50 MHz clock with a 2-clk pixel phase; all pins registered.
module vga_layer_mixer #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int NUM_LAYERS = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [29:0]                bg_rgb,
   input  logic [30*NUM_LAYERS-1:0]   layer_rgb,
   input  logic [NUM_LAYERS-1:0]      layer_printed,
   output logic [9:0]                 px,
   output logic [9:0]                 py,
   output logic [9:0]                 vga_r,
   output logic [9:0]                 vga_g,
   output logic [9:0]                 vga_b,
   output logic                       vga_hs,
   output logic                       vga_vs,
   output logic                       vga_blank_n,
   output logic                       vga_sync_n,
   output logic                       vga_clk,
   output logic                       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] HV   = 10'(H_VISIBLE);
   localparam logic [9:0] HS0  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS1  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] HMAX = 10'(H_TOTAL - 1);
   localparam logic [9:0] VV   = 10'(V_VISIBLE);
   localparam logic [9:0] VS0  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS1  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] VMAX = 10'(V_TOTAL - 1);

   logic        ph;
   logic        vis;
   logic [29:0] mix;

   assign vga_clk    = ph;
   assign vga_sync_n = 1'b0;
   assign vis        = (px < HV) && (py < VV);

   // Walk from lowest priority up so layer 0 overrides everything.
   always_comb begin
      mix = bg_rgb;
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
         if (layer_printed[k]) mix = layer_rgb[30*k +: 30];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ph          <= 1'b0;
         px          <= '0;
         py          <= '0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_blank_n <= 1'b0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         ph          <= ~ph;
         frame_start <= 1'b0;
         if (ph) begin
            {vga_r, vga_g, vga_b} <= vis ? mix : 30'd0;
            vga_blank_n <= vis;
            vga_hs      <= !((px >= HS0) && (px <= HS1));
            vga_vs      <= !((py >= VS0) && (py <= VS1));
            if (px == HMAX) begin
               px          <= '0;
               py          <= (py == VMAX) ? 10'd0 : py + 10'd1;
               frame_start <= (py == VMAX);
            end else begin
               px <= px + 10'd1;
            end
         end
      end
   end

endmodule
